// File: rtl/change_pkg.sv
// Shared definitions for the change dispenser: coin denomination codes,
// their rupee values, FSM state encoding and default tube fill level.
package change_pkg;

    localparam logic [1:0] DEN_5  = 2'b00;
    localparam logic [1:0] DEN_10 = 2'b01;
    localparam logic [1:0] DEN_20 = 2'b10;
    localparam logic [1:0] DEN_50 = 2'b11;

    localparam int unsigned INIT_CNT_DEF = 15;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SELECT = 2'b01,
        S_ISSUE  = 2'b10,
        S_FINISH = 2'b11
    } state_t;

    function automatic logic [5:0] den_value(input logic [1:0] den);
        logic [5:0] v;
        case (den)
            DEN_5:   v = 6'd5;
            DEN_10:  v = 6'd10;
            DEN_20:  v = 6'd20;
            default: v = 6'd50;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_tube_counter.sv
// Inventory counter for one coin tube; refill reloads to INIT_CNT and
// decrement saturates at zero.
module coin_tube_counter #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned INIT_CNT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             refill,
    input  logic             decrement,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (refill) begin
            count_d = CNT_W'(INIT_CNT);
        end else if (decrement && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= CNT_W'(INIT_CNT);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin payout controller: greedy selection over four tubes, paying one coin
// per hopper handshake and reporting unpaid residue at the end.
module change_dispenser
    import change_pkg::*;
#(
    parameter int unsigned AMT_W    = 7,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned INIT_CNT = INIT_CNT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic [AMT_W-1:0] change,
    input  logic             refill,
    output logic             busy,
    output logic             coin_valid,
    output logic [1:0]       coin_den,
    input  logic             coin_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] residue,
    output logic [3:0]       empty
);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [1:0]       den_q, den_d;
    logic             coin_valid_q, coin_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [AMT_W-1:0] residue_q, residue_d;

    logic [CNT_W-1:0] tube_cnt [4];
    logic [3:0]       tube_dec;
    logic             tube_refill;
    logic             pick_found;
    logic [1:0]       pick_den;

    for (genvar g = 0; g < 4; g++) begin : g_tube
        coin_tube_counter #(
            .CNT_W    (CNT_W),
            .INIT_CNT (INIT_CNT)
        ) u_tube (
            .clock     (clock),
            .reset     (reset),
            .refill    (tube_refill),
            .decrement (tube_dec[g]),
            .count     (tube_cnt[g]),
            .empty     (empty[g])
        );
    end

    // Ascending scan: the last qualifying tube is the largest denomination.
    always_comb begin
        pick_found = 1'b0;
        pick_den   = DEN_5;
        for (int unsigned i = 0; i < 4; i++) begin
            if ((AMT_W'(den_value(2'(i))) <= rem_q) && (tube_cnt[i] != '0)) begin
                pick_found = 1'b1;
                pick_den   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        den_d        = den_q;
        coin_valid_d = coin_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        short_d      = short_q;
        residue_d    = residue_q;
        tube_dec     = '0;
        tube_refill  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    rem_d     = change;
                    short_d   = 1'b0;
                    residue_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SELECT;
                end else if (refill) begin
                    tube_refill = 1'b1;
                end
            end
            S_SELECT: begin
                if (pick_found) begin
                    den_d        = pick_den;
                    coin_valid_d = 1'b1;
                    state_d      = S_ISSUE;
                end else begin
                    done_d    = 1'b1;
                    residue_d = rem_q;
                    short_d   = (rem_q != '0);
                    state_d   = S_FINISH;
                end
            end
            S_ISSUE: begin
                if (coin_ack) begin
                    rem_d           = rem_q - AMT_W'(den_value(den_q));
                    tube_dec[den_q] = 1'b1;
                    coin_valid_d    = 1'b0;
                    state_d         = S_SELECT;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            den_q        <= DEN_5;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            residue_q    <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            den_q        <= den_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_q      <= short_d;
            residue_q    <= residue_d;
        end
    end

    assign busy       = busy_q;
    assign coin_valid = coin_valid_q;
    assign coin_den   = den_q;
    assign done       = done_q;
    assign short      = short_q;
    assign residue    = residue_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a behavioural payout model predicts
// coin sequences and completion results; a monitor checks the DUT against them.
module tb_change_dispenser;

    localparam int AMT_W    = 7;
    localparam int CNT_W    = 4;
    localparam int INIT_CNT = 15;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req = 1'b0;
    logic [AMT_W-1:0] change = '0;
    logic             refill = 1'b0;
    logic             busy;
    logic             coin_valid;
    logic [1:0]       coin_den;
    logic             coin_ack = 1'b0;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] residue;
    logic [3:0]       empty;

    change_dispenser #(
        .AMT_W    (AMT_W),
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .change     (change),
        .refill     (refill),
        .busy       (busy),
        .coin_valid (coin_valid),
        .coin_den   (coin_den),
        .coin_ack   (coin_ack),
        .done       (done),
        .short      (short),
        .residue    (residue),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        int res;
        int shrt;
        int emp;
    } result_t;

    int      total = 0;
    int      bad = 0;
    int      coin_q[$];
    result_t res_q[$];
    int      cnt[4];
    int      values[4] = '{5, 10, 20, 50};
    bit      ack_hold = 0;
    bit      ack_rand = 0;
    bit      stall_prev = 0;
    int      stall_den = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_empty();
        int e = 0;
        for (int d = 0; d < 4; d++) if (cnt[d] == 0) e |= (1 << d);
        return e;
    endfunction

    // Reference payout: largest coin value not above the remaining amount
    // among the tubes that still hold coins, repeated until none fits.
    task automatic model_payout(input int amt);
        int      rem = amt;
        int      pick;
        result_t r;
        forever begin
            pick = -1;
            for (int d = 3; d >= 0; d--) begin
                if (pick < 0 && values[d] <= rem && cnt[d] > 0) pick = d;
            end
            if (pick < 0) break;
            coin_q.push_back(pick);
            cnt[pick]--;
            rem -= values[pick];
        end
        r.res  = rem;
        r.shrt = (rem != 0) ? 1 : 0;
        r.emp  = model_empty();
        res_q.push_back(r);
    endtask

    always begin
        @(posedge clock);
        #2;
        if (ack_hold)      coin_ack = 1'b0;
        else if (ack_rand) coin_ack = 1'($urandom_range(0, 1));
        else               coin_ack = 1'b1;
    end

    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", int'(coin_valid), 1);
                check("stall_den", int'(coin_den), stall_den);
            end
            stall_prev = coin_valid && !coin_ack;
            stall_den  = int'(coin_den);
            if (coin_valid && coin_ack) begin
                if (coin_q.size() == 0) begin
                    check("unexpected_coin", int'(coin_den), -1);
                end else begin
                    check("coin_den", int'(coin_den), coin_q.pop_front());
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    result_t r;
                    r = res_q.pop_front();
                    check("residue", int'(residue), r.res);
                    check("short", int'(short), r.shrt);
                    check("empty", int'(empty), r.emp);
                    check("coins_left", coin_q.size(), 0);
                end
            end
        end
    end

    task automatic do_req(input int amt, input bit with_refill);
        req    = 1'b1;
        change = AMT_W'(amt);
        refill = with_refill;
        model_payout(amt);
        @(posedge clock);
        #1;
        req    = 1'b0;
        refill = 1'b0;
    endtask

    task automatic do_refill();
        refill = 1'b1;
        for (int d = 0; d < 4; d++) cnt[d] = INIT_CNT;
        @(posedge clock);
        #1;
        refill = 1'b0;
    endtask

    task automatic wait_idle(input bit noise);
        int n = 0;
        while (busy) begin
            @(posedge clock);
            #1;
            req    = 1'b0;
            refill = 1'b0;
            if (busy && noise && $urandom_range(0, 5) == 0) begin
                req    = 1'b1;
                change = AMT_W'($urandom_range(0, 127));
                refill = 1'($urandom_range(0, 1));
            end
            n++;
            if (n > 500) begin
                check("idle_timeout", n, 0);
                req    = 1'b0;
                refill = 1'b0;
                return;
            end
        end
        req    = 1'b0;
        refill = 1'b0;
    endtask

    initial begin
        int amt;
        for (int d = 0; d < 4; d++) cnt[d] = INIT_CNT;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(coin_valid), 0);
        check("rst_den", int'(coin_den), 0);
        check("rst_done", int'(done), 0);
        check("rst_short", int'(short), 0);
        check("rst_residue", int'(residue), 0);
        check("rst_empty", int'(empty), 0);
        @(posedge clock);
        #1;

        // 85 with ack tied high: 50,20,10,5 and first coin two cycles out
        do_req(85, 1'b0);
        @(negedge clock);
        check("b85_busy", int'(busy), 1);
        check("b85_valid_n1", int'(coin_valid), 0);
        @(negedge clock);
        check("b85_valid_n2", int'(coin_valid), 1);
        check("b85_first_den", int'(coin_den), 3);
        wait_idle(1'b0);

        // zero change: done two cycles after acceptance, no coin
        do_req(0, 1'b0);
        @(negedge clock);
        check("z_done_n1", int'(done), 0);
        check("z_valid_n1", int'(coin_valid), 0);
        @(negedge clock);
        check("z_done_n2", int'(done), 1);
        check("z_valid_n2", int'(coin_valid), 0);
        wait_idle(1'b0);

        // not a multiple of five
        do_req(7, 1'b0);
        wait_idle(1'b0);

        // backpressure on a 20 payout with an ignored req of 50 mid-stall
        ack_hold = 1;
        do_req(20, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check("bp_valid", int'(coin_valid), 1);
        check("bp_den", int'(coin_den), 2);
        @(posedge clock);
        #1;
        req    = 1'b1;
        change = AMT_W'(50);
        @(posedge clock);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        ack_hold = 0;
        wait_idle(1'b0);
        check("bp_coin_q", coin_q.size(), 0);

        // reset while a coin is being offered during 70
        ack_hold = 1;
        do_req(70, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        coin_q.delete();
        res_q.delete();
        for (int d = 0; d < 4; d++) cnt[d] = INIT_CNT;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        ack_hold = 0;
        @(negedge clock);
        check("ar_valid", int'(coin_valid), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_done", int'(done), 0);
        check("ar_empty", int'(empty), 0);
        @(posedge clock);
        #1;
        do_req(70, 1'b0);
        wait_idle(1'b0);

        // req and refill together after draining the 50 tube: refill dropped
        for (int k = 0; k < 8; k++) begin
            do_req(100, 1'b0);
            wait_idle(1'b0);
        end
        do_req(100, 1'b1);
        wait_idle(1'b0);
        do_refill();

        // randomized traffic with random hopper acks and noise while busy
        ack_rand = 1;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_refill();
            end else begin
                amt = $urandom_range(0, 127);
                do_req(amt, ($urandom_range(0, 4) == 0));
                wait_idle(1'b1);
            end
        end
        ack_rand = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("end_coin_q", coin_q.size(), 0);
        check("end_res_q", res_q.size(), 0);
        check("end_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin payout unit on the output side of the vending machine. It accepts a change amount from the vending controller and pays it out one coin at a time to a coin hopper over a valid/ack handshake. It selects greedily from four coin tubes (50, 20, 10, 5) and keeps a per-tube inventory. It reports completion and any unpaid residue when tubes run dry or the amount is not a multiple of 5.

## Interface
Parameters:
- AMT_W, 7, width of change amount and residue
- CNT_W, 4, width of each tube counter
- INIT_CNT, 15, coins per tube after reset or refill; must fit in CNT_W

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  1  change request; sampled only in IDLE
- change  in  AMT_W  amount in rupees, captured with req
- refill  in  1  reload all tubes to INIT_CNT; honoured only in IDLE
- busy  out  1  payout in progress
- coin_valid  out  1  coin offered to hopper
- coin_den  out  2  denomination of offered coin: 00=5, 01=10, 10=20, 11=50
- coin_ack  in  1  hopper accepts the offered coin
- done  out  1  one-cycle pulse at end of payout
- short  out  1  residue nonzero; valid with done, held until next accepted req
- residue  out  AMT_W  unpaid amount; valid with done, held until next accepted req
- empty  out  4  per-tube empty flags, bit index = coin_den code

## Operation
- The FSM has four states: IDLE, SELECT, ISSUE, FINISH.
- IDLE: when req=1, capture change into rem, clear short and residue, and go to SELECT. Otherwise, if refill=1, set all counts to INIT_CNT.
- SELECT: pick the largest denomination d with value ≤ rem and count[d] > 0.
  - If one is found, latch it into coin_den and go to ISSUE.
  - If none is found, go to FINISH.
- ISSUE: coin_valid=1 and coin_den stays stable until coin_ack=1.
  - On ack: rem -= value(d), count[d] -= 1, go to SELECT.
- FINISH: done=1 for one cycle, residue=rem, short=(rem≠0), then go to IDLE.
- busy=1 in SELECT, ISSUE and FINISH.
- Arithmetic is unsigned AMT_W bits. Greedy selection never lets rem underflow. Counts never go below 0.
- empty[d] = (count[d]==0), derived combinationally from the counters.
- Boundary conditions:
  - change=0: no coin is issued; FINISH is reached with residue 0.
  - change not a multiple of 5: the remainder below 5 is left as residue and short=1.
  - req while busy: ignored, not queued.
  - refill while busy: ignored.
  - req and refill in the same IDLE cycle: req wins and refill is dropped.
  - coin_ack while coin_valid=0: ignored.
  - Reset mid-payout: abort with no completion. Next cycle all outputs are 0, state is IDLE, and counts equal INIT_CNT.

## Timing
- Reset values: busy=0, coin_valid=0, coin_den=00, done=0, short=0, residue=0, counts=INIT_CNT, empty=0000.
- req accepted at edge N: busy=1 after N, SELECT during cycle N+1, coin_valid=1 during cycle N+2 if a coin is available.
- Per coin: minimum 2 cycles (ISSUE with same-cycle ack, then SELECT). Hopper stalls add 1 cycle per cycle without ack.
- Last ack at edge M: SELECT in M+1, FINISH/done in M+2, IDLE and busy=0 in M+3.
- Empty request: done is asserted 2 cycles after the accepting edge.
- All outputs are registered except empty.

## Structure
- Package change_pkg holds:
  - the denomination code constants DEN_5/10/20/50 and the value lookup (5, 10, 20, 50)
  - the state encoding
  - the default INIT_CNT
- Sub-module coin_tube_counter holds one tube inventory, with:
  - inputs: decrement, refill, reset
  - outputs: count and empty, saturating at 0
  - it is instantiated four times.
- The top level contains the FSM, the rem register and the greedy select logic.

## Test plan
- Reset, then req with change=85 and ack tied high: coins issued 50, 20, 10, 5 in order; done with residue 0, short 0; each tube count = 14.
- change=0: done 2 cycles after req, coin_valid never asserted, residue 0.
- INIT_CNT=2, req 100, then req 100 again:
  - first payout is 50, 50, and empty[3]=1
  - second payout is 20, 20, 10, 10, 5, 5, then done with residue 30 and short=1
- Hopper backpressure with coin_ack held low 5 cycles during change=20: coin_valid and coin_den=10 stay stable. A req of 50 pulsed meanwhile is ignored and only one coin is paid.
- change=7: one 5 coin, then done with residue 2, short=1.
- Reset asserted in ISSUE during change=70: next cycle coin_valid=0, busy=0, done=0 and counts=INIT_CNT. A following change=70 completes normally with 50, 20.
